// File: rtl/mac_dbg_unit.sv
// Debug/statistics block: CTRL/STICKY/CYCLES/EVT counters plus live status words behind a simple req/gnt bus.
// Latency: every accepted transaction answers with r_valid_o exactly one cycle later (read data or 0 for writes).
// Backpressure: none; gnt_o is tied high and a transaction is taken on every cycle with req_i=1.
//
// Ports:
//   clk_i, rst_ni, clear_i           clock, async active-low reset, synchronous clear
//   req_i/add_i/wen_i/data_i/id_i    request (wen_i: 0 = write, 1 = read), word index = add_i[7:2]
//   gnt_o, r_data_o/r_valid_o/r_id_o grant and registered response
//   start_i, done_i                  job start/done pulses driving the IDLE/RUN FSM
//   evt_i[N_CNT-1:0]                 per-counter event strobes
//   status_i[N_STATUS*32-1:0]        live status words, word k at bits [32k +: 32]
module mac_dbg_unit #(
  parameter int N_CNT    = 4,
  parameter int N_STATUS = 8,
  parameter int CNT_W    = 32,
  parameter int ID_WIDTH = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     req_i,
  input  logic [31:0]              add_i,
  input  logic                     wen_i,
  input  logic [31:0]              data_i,
  input  logic [ID_WIDTH-1:0]      id_i,
  output logic                     gnt_o,
  output logic [31:0]              r_data_o,
  output logic                     r_valid_o,
  output logic [ID_WIDTH-1:0]      r_id_o,
  input  logic                     start_i,
  input  logic                     done_i,
  input  logic [N_CNT-1:0]         evt_i,
  input  logic [N_STATUS*32-1:0]   status_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic             freeze;
  logic [2:0]       sticky;
  logic [2:0]       sticky_nxt;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] evt [N_CNT];

  logic [5:0]       idx;
  logic             running;
  logic             cnt_en;
  logic [N_CNT-1:0] evt_inc;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_sticky;
  logic             cnt_clr;
  logic             sat_hit;
  logic [31:0]      rd_val;

  // Address bits outside the word index and the upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{add_i[31:8], add_i[1:0], data_i[31:3]};

  assign gnt_o     = 1'b1;
  assign idx       = add_i[7:2];
  assign running   = (state == ST_RUN);
  assign cnt_en    = running & ~freeze;
  assign evt_inc   = evt_i & {N_CNT{cnt_en}};
  assign wr        = req_i & ~wen_i;
  assign wr_ctrl   = wr & (idx == 6'd0);
  assign wr_sticky = wr & (idx == 6'd1);
  // CTRL bit0 is a command, not state: it only zeroes the counters on this edge.
  assign cnt_clr   = wr_ctrl & data_i[0];

  // Read mux sees the current (pre-update) register values.
  always_comb begin
    rd_val = 32'd0;
    if (idx == 6'd0) rd_val = {30'd0, freeze, running};
    if (idx == 6'd1) rd_val = {29'd0, sticky};
    if (idx == 6'd2) rd_val[CNT_W-1:0] = cycles;
    for (int k = 0; k < N_CNT; k++) begin
      if (idx == 6'(4 + k)) rd_val[CNT_W-1:0] = evt[k];
    end
    for (int k = 0; k < N_STATUS; k++) begin
      if (idx == 6'(16 + k)) rd_val = status_i[k*32 +: 32];
    end
  end

  // Saturation flag fires only when an increment actually lands on the max value,
  // so a clear-write or a start reload in the same cycle suppresses it.
  always_comb begin
    sat_hit = 1'b0;
    if (!cnt_clr) begin
      if (cnt_en && !start_i && cycles == CNT_NEAR) sat_hit = 1'b1;
      for (int k = 0; k < N_CNT; k++) begin
        if (evt_inc[k] && evt[k] == CNT_NEAR) sat_hit = 1'b1;
      end
    end
  end

  // W1C first, then set events on top so a set in the same cycle wins.
  always_comb begin
    sticky_nxt = sticky;
    if (wr_sticky) sticky_nxt = sticky & ~data_i[2:0];
    if (start_i)            sticky_nxt[0] = 1'b1;
    if (done_i && running)  sticky_nxt[1] = 1'b1;
    if (sat_hit)            sticky_nxt[2] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      freeze <= 1'b0;
      sticky <= 3'd0;
    end else if (clear_i) begin
      state  <= ST_IDLE;
      freeze <= 1'b0;
      sticky <= 3'd0;
    end else begin
      // start beats done, including the restart case while already running
      if (start_i)                state <= ST_RUN;
      else if (done_i && running) state <= ST_IDLE;
      if (wr_ctrl) freeze <= data_i[1];
      sticky <= sticky_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles <= '0;
    end else if (clear_i || cnt_clr || start_i) begin
      cycles <= '0;
    end else if (cnt_en && cycles != CNT_MAX) begin
      cycles <= cycles + CNT_ONE;
    end
  end

  // Event counters are not touched by start; only clear paths zero them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_CNT; k++) evt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        if (clear_i || cnt_clr)                  evt[k] <= '0;
        else if (evt_inc[k] && evt[k] != CNT_MAX) evt[k] <= evt[k] + CNT_ONE;
      end
    end
  end

  // Response pipeline; clear drops whatever was accepted in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= 32'd0;
      r_id_o    <= '0;
    end else if (clear_i) begin
      r_valid_o <= 1'b0;
      r_data_o  <= 32'd0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= req_i;
      if (req_i) begin
        r_data_o <= wen_i ? rd_val : 32'd0;
        r_id_o   <= id_i;
      end
    end
  end

endmodule

// File: tb/tb_mac_dbg_unit.sv
// Directed bench for mac_dbg_unit with CNT_W=16 so saturation is reachable.
// Table of single-cycle bus accesses, then hand-written multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mac_dbg_unit;

  localparam int N_CNT = 4;
  localparam int N_STATUS = 8;
  localparam int CNT_W = 16;
  localparam int IDW = 10;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   clear_i = 1'b0;
  logic                   req_i = 1'b0;
  logic [31:0]            add_i = 32'd0;
  logic                   wen_i = 1'b1;
  logic [31:0]            data_i = 32'd0;
  logic [IDW-1:0]         id_i = '0;
  logic                   gnt_o;
  logic [31:0]            r_data_o;
  logic                   r_valid_o;
  logic [IDW-1:0]         r_id_o;
  logic                   start_i = 1'b0;
  logic                   done_i = 1'b0;
  logic [N_CNT-1:0]       evt_i = '0;
  logic [N_STATUS*32-1:0] status_i = '0;

  int total = 0;
  int bad = 0;
  logic [IDW-1:0] next_id = 10'h100;

  mac_dbg_unit #(
    .N_CNT(N_CNT), .N_STATUS(N_STATUS), .CNT_W(CNT_W), .ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .id_i(id_i),
    .gnt_o(gnt_o), .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o),
    .start_i(start_i), .done_i(done_i), .evt_i(evt_i), .status_i(status_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic [5:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus access lasting exactly one cycle; checks the response on the following sample.
  task automatic acc(input string name, input logic rd, input logic [5:0] idx,
                     input logic [31:0] wd, input logic [31:0] exp);
    logic [IDW-1:0] id;
    id = next_id;
    next_id = next_id + 10'd1;
    req_i = 1'b1; add_i = {24'd0, idx, 2'b00}; wen_i = rd; data_i = wd; id_i = id;
    @(posedge clk_i); #1;
    req_i = 1'b0; wen_i = 1'b1; data_i = 32'd0;
    check({name, " valid/id"}, 32'({r_valid_o, r_id_o}), 32'({1'b1, id}));
    check({name, " data"}, r_data_o, exp);
  endtask

  task automatic cyc(input logic st, input logic dn);
    start_i = st; done_i = dn;
    @(posedge clk_i); #1;
    start_i = 1'b0; done_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N_STATUS; k++) status_i[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);

    tbl[0]  = '{1'b1, 6'd0,  32'h0,        32'h0};
    tbl[1]  = '{1'b1, 6'd1,  32'h0,        32'h0};
    tbl[2]  = '{1'b1, 6'd2,  32'h0,        32'h0};
    tbl[3]  = '{1'b1, 6'd4,  32'h0,        32'h0};
    tbl[4]  = '{1'b1, 6'd7,  32'h0,        32'h0};
    tbl[5]  = '{1'b1, 6'd16, 32'h0,        32'hA5A5_0000};
    tbl[6]  = '{1'b1, 6'd17, 32'h0,        32'hA5A5_0001};
    tbl[7]  = '{1'b1, 6'd23, 32'h0,        32'hA5A5_0007};
    tbl[8]  = '{1'b1, 6'd24, 32'h0,        32'h0};
    tbl[9]  = '{1'b1, 6'd3,  32'h0,        32'h0};
    tbl[10] = '{1'b1, 6'd63, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 6'd16, 32'hFFFF_FFFF, 32'h0};
    tbl[12] = '{1'b0, 6'd2,  32'h0000_1234, 32'h0};
    tbl[13] = '{1'b1, 6'd2,  32'h0,        32'h0};
    tbl[14] = '{1'b0, 6'd0,  32'h0000_0002, 32'h0};
    tbl[15] = '{1'b1, 6'd0,  32'h0,        32'h2};
    tbl[16] = '{1'b0, 6'd0,  32'h0,        32'h0};
    tbl[17] = '{1'b1, 6'd0,  32'h0,        32'h0};
    tbl[18] = '{1'b1, 6'd16, 32'h0,        32'hA5A5_0000};

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst r_valid", 32'(r_valid_o), 32'd0);
    check("rst r_data", r_data_o, 32'd0);
    check("rst r_id", 32'(r_id_o), 32'd0);
    check("gnt", 32'(gnt_o), 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // register map sweep from idle
    for (int i = 0; i < 19; i++) acc($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].idx, tbl[i].wd, tbl[i].exp);

    // start, 10 run cycles, done: cycles counts the done cycle too
    cyc(1'b1, 1'b0);
    acc("ctrl running", 1'b1, 6'd0, 32'h0, 32'h1);   // this read is a RUN cycle as well
    repeat (9) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    acc("cycles 11", 1'b1, 6'd2, 32'h0, 32'd11);
    acc("sticky 3", 1'b1, 6'd1, 32'h0, 32'h3);
    acc("sticky w1c", 1'b0, 6'd1, 32'h1, 32'h0);
    acc("sticky 2", 1'b1, 6'd1, 32'h0, 32'h2);
    cyc(1'b0, 1'b1);                                  // done while idle is ignored
    acc("ctrl idle", 1'b1, 6'd0, 32'h0, 32'h0);
    acc("sticky still 2", 1'b1, 6'd1, 32'h0, 32'h2);

    // event counting with freeze on for two of five event cycles
    cyc(1'b1, 1'b0);
    evt_i = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 1)      acc("frz on", 1'b0, 6'd0, 32'h2, 32'h0);
      else if (i == 3) acc("frz off", 1'b0, 6'd0, 32'h0, 32'h0);
      else             cyc(1'b0, 1'b0);
    end
    evt_i = 4'b0000;
    acc("cycles pre-update", 1'b1, 6'd2, 32'h0, 32'd3);
    acc("evt2 3", 1'b1, 6'd6, 32'h0, 32'd3);
    acc("evt0 0", 1'b1, 6'd4, 32'h0, 32'd0);
    acc("ctrl clr", 1'b0, 6'd0, 32'h1, 32'h0);
    acc("cycles cleared", 1'b1, 6'd2, 32'h0, 32'd0);
    acc("evt2 cleared", 1'b1, 6'd6, 32'h0, 32'd0);

    // start+done together while running: stays RUN, cycles restart
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    acc("restart cycles 0", 1'b1, 6'd2, 32'h0, 32'd0);
    acc("restart running", 1'b1, 6'd0, 32'h0, 32'h1);
    acc("restart cycles 2", 1'b1, 6'd2, 32'h0, 32'd2);

    // clear mid-run drops the pending response and stops counting
    clear_i = 1'b1; req_i = 1'b1; add_i = 32'h8; wen_i = 1'b1; id_i = 10'h3FF;
    @(posedge clk_i); #1;
    clear_i = 1'b0; req_i = 1'b0;
    check("clear drops resp", 32'(r_valid_o), 32'd0);
    acc("clear ctrl", 1'b1, 6'd0, 32'h0, 32'h0);
    acc("clear cycles", 1'b1, 6'd2, 32'h0, 32'd0);
    acc("clear sticky", 1'b1, 6'd1, 32'h0, 32'h0);

    // back-to-back reads
    req_i = 1'b1; wen_i = 1'b1; add_i = {24'd0, 6'd16, 2'b00}; id_i = 10'd1;
    @(posedge clk_i); #1;
    check("b2b0 data", r_data_o, 32'hA5A5_0000);
    check("b2b0 valid/id", 32'({r_valid_o, r_id_o}), 32'({1'b1, 10'd1}));
    add_i = {24'd0, 6'd17, 2'b00}; id_i = 10'd2;
    @(posedge clk_i); #1;
    check("b2b1 data", r_data_o, 32'hA5A5_0001);
    check("b2b1 valid/id", 32'({r_valid_o, r_id_o}), 32'({1'b1, 10'd2}));
    add_i = {24'd0, 6'd40, 2'b00}; id_i = 10'd3;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    check("b2b2 data", r_data_o, 32'h0);
    check("b2b2 valid/id", 32'({r_valid_o, r_id_o}), 32'({1'b1, 10'd3}));
    @(posedge clk_i); #1;
    check("b2b idle valid", 32'(r_valid_o), 32'd0);

    // set beats W1C in the same cycle, then saturate EVT[0] and CYCLES
    start_i = 1'b1;
    acc("w1c vs start", 1'b0, 6'd1, 32'h7, 32'h0);
    start_i = 1'b0;
    acc("sticky set wins", 1'b1, 6'd1, 32'h0, 32'h1);
    evt_i = 4'b0001;
    repeat (70000) @(posedge clk_i);
    #1;
    evt_i = 4'b0000;
    cyc(1'b0, 1'b1);
    acc("evt0 sat", 1'b1, 6'd4, 32'h0, 32'h0000_FFFF);
    acc("evt1 zero", 1'b1, 6'd5, 32'h0, 32'h0);
    acc("cycles sat", 1'b1, 6'd2, 32'h0, 32'h0000_FFFF);
    acc("sticky sat", 1'b1, 6'd1, 32'h0, 32'h7);

    // asynchronous reset between edges while a response is showing
    #2 rst_ni = 1'b0;
    #1;
    check("async rst valid", 32'(r_valid_o), 32'd0);
    check("async rst data", r_data_o, 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    acc("post rst sticky", 1'b1, 6'd1, 32'h0, 32'h0);
    acc("post rst evt0", 1'b1, 6'd4, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_dbg_unit.md
MAC_DBG_UNIT -- requirements
Module: mac_dbg_unit

Interface
REQ-001 SHALL have parameter N_CNT, default 4: number of event counters, legal 1..8.
REQ-002 SHALL have parameter N_STATUS, default 8: number of live status words, legal 1..16.
REQ-003 SHALL have parameter CNT_W, default 32: counter width, legal 16..32.
REQ-004 SHALL have parameter ID_WIDTH, default 10: transaction ID width.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of all state.
- req_i  in  1  request.
- add_i  in  32  byte address.
- wen_i  in  1  0 = write, 1 = read.
- data_i  in  32  write data.
- id_i  in  ID_WIDTH  request ID.
- gnt_o  out  1  grant.
- r_data_o  out  32  read data.
- r_valid_o  out  1  response valid.
- r_id_o  out  ID_WIDTH  response ID.
- start_i  in  1  job-start pulse.
- done_i  in  1  job-done pulse.
- evt_i  in  N_CNT  per-counter event strobes.
- status_i  in  N_STATUS x 32  live status words.

Function
REQ-006 SHALL tie gnt_o to 1; a transaction is accepted on every cycle where req_i=1.
REQ-007 SHALL assert r_valid_o exactly one cycle after each accepted transaction, read or write, with r_id_o = the accepted id_i.
REQ-008 SHALL register r_data_o from the register value sampled in the accept cycle; writes return 0.
REQ-009 SHALL decode the word index add_i[7:2] as follows:
- 0: CTRL.
- 1: STICKY.
- 2: CYCLES.
- 4..4+N_CNT-1: EVT[k].
- 16..16+N_STATUS-1: status_i[k] (live).
- All other indices read 0; writes to them are ignored.
REQ-010 CTRL SHALL read {30'b0, freeze, running}; a write with data_i[1] SHALL set freeze to data_i[1]; a write with data_i[0]=1 SHALL zero CYCLES and all EVT in the next cycle (self-clearing, not stored).
REQ-011 STICKY SHALL hold three flags: bit0 started, bit1 done, bit2 saturated; a write SHALL clear each bit where data_i is 1 (W1C).
REQ-012 In the same cycle, a set event SHALL win over W1C.
REQ-013 Writes to CYCLES, EVT and status indices SHALL be ignored.
REQ-014 SHALL implement a two-state FSM, IDLE and RUN; running = (state==RUN).
REQ-015 FSM transitions SHALL be:
- IDLE -> RUN on start_i; CYCLES is loaded with 0 and EVT are unchanged.
- RUN -> IDLE on done_i.
- start_i in RUN: stays RUN and reloads CYCLES with 0 (restart).
- start_i and done_i in the same cycle: start wins, state = RUN.
REQ-016 start_i SHALL set STICKY.started; done_i in RUN SHALL set STICKY.done; done_i in IDLE SHALL be ignored.
REQ-017 CYCLES SHALL increment by 1 on each RUN cycle with freeze=0, including the cycle in which done_i is sampled.
REQ-018 EVT[k] SHALL increment on each cycle where evt_i[k]=1, state==RUN and freeze=0.
REQ-019 All counters SHALL saturate at 2^CNT_W-1; reaching saturation SHALL set STICKY.saturated.
REQ-020 Counters SHALL be zero-extended to 32 bits on read.
REQ-021 Counter priority SHALL be: clear_i > CTRL clear-write > start reload > increment.
REQ-022 A read of a counter in the same cycle as its update SHALL return the pre-update value.

Reset
REQ-023 While rst_ni=0 the block SHALL be asynchronously forced to its reset values:
- state IDLE, freeze 0, STICKY 0, CYCLES 0, EVT 0.
- r_valid_o 0, r_data_o 0, r_id_o 0.
REQ-024 clear_i=1 SHALL load the same values on the next edge and drop any pending response (r_valid_o=0 next cycle).
REQ-025 Reset or clear asserted mid-RUN SHALL abort counting with no further increments.

Verification
REQ-026 Reset, then read index 1 -> r_valid_o one cycle later, r_data_o=0, r_id_o echoes id_i.
REQ-027 start_i, 10 RUN cycles, then done_i; read CYCLES -> 11; read STICKY -> 0x3; write 0x1 to STICKY -> then reads 0x2.
REQ-028 In RUN, evt_i[2] high for 5 cycles, freeze=1 for 2 of them; read EVT[2] -> 3.
REQ-029 CNT_W=16, evt_i[0] high for 70000 RUN cycles -> EVT[0]=0xFFFF and STICKY bit2=1.
REQ-030 start_i and done_i asserted together in RUN -> state stays RUN and CYCLES restarts from 0.
REQ-031 Back-to-back reads of indices 16, 17, 40 on consecutive cycles -> three consecutive r_valid_o returning status_i[0], status_i[1], 0.
